// File: rtl/board_debug_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// board_dbg_pkg
//   Shared types and constants for the board debug controller.
//   - state_t    : run/step/halt/break controller state encoding
//   - HEX_SEG    : active-low {dp,g,f,e,d,c,b,a} patterns for hex digits 0-F
//   - clog2()    : counter width helper (never returns less than 1)
// Optional build macro used by files importing this package:
//   BOARD_DBG_FREEZE_EN - adds a display-freeze input to the bus.
// ---------------------------------------------------------------------------
package board_dbg_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

    // Index 0 is the rightmost entry. Bit 7 (dp) is always 1, i.e. off.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
        8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    // Bits needed to hold values 0..value-1; at least 1 so that a counter
    // with a single state still has a legal declaration.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if (((value - 1) >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/board_debug_ctrl_if.sv
// ---------------------------------------------------------------------------
// board_dbg_if
//   Bundles every non-clock/reset signal of board_debug_ctrl.
//   slave  : the controller side (consumes run/step/probes, drives display)
//   master : the board/test side
// Signalling: there is no valid/ready handshake on this bus. run, choose,
// probe, pc, inst, bp_addr, bp_ena (and freeze) are levels sampled every
// clk; step_btn is an asynchronous level whose rising edges are counted;
// cpu_en is a single-clk enable pulse; halted, state, step_count, o_seg and
// o_sel are levels valid every clk.
// Optional macro: BOARD_DBG_FREEZE_EN adds the freeze input.
// ---------------------------------------------------------------------------
interface board_dbg_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 32,
    parameter int DIGITS = 8
);
    import board_dbg_pkg::*;

    logic                       run;
    logic                       step_btn;
    logic [NUM_CH-1:0]          choose;
    logic [NUM_CH*DATA_W-1:0]   probe;
    logic [DATA_W-1:0]          pc;
    logic [DATA_W-1:0]          inst;
    logic [DATA_W-1:0]          bp_addr;
    logic                       bp_ena;
`ifdef BOARD_DBG_FREEZE_EN
    logic                       freeze;
`endif
    logic                       cpu_en;
    logic                       halted;
    logic [31:0]                step_count;
    logic [7:0]                 o_seg;
    logic [DIGITS-1:0]          o_sel;
    state_t                     state;      // controller state, for debug

    modport slave (
`ifdef BOARD_DBG_FREEZE_EN
        input  freeze,
`endif
        input  run, step_btn, choose, probe, pc, inst, bp_addr, bp_ena,
        output cpu_en, halted, step_count, o_seg, o_sel, state
    );

    modport master (
`ifdef BOARD_DBG_FREEZE_EN
        output freeze,
`endif
        output run, step_btn, choose, probe, pc, inst, bp_addr, bp_ena,
        input  cpu_en, halted, step_count, o_seg, o_sel, state
    );

endinterface

// File: rtl/board_debug_ctrl_seg_hex_scan.sv
// ---------------------------------------------------------------------------
// seg_hex_scan
//   Multiplexed 7-segment hex scanner. Advances the digit index every
//   SEG_DIV clks (wrapping DIGITS-1 -> 0), latches the display word once per
//   scan as digit 0 begins, and registers o_sel/o_seg together so both lag
//   the digit index by exactly one clk. Digit d shows nibble d.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   word     : word to display, sampled at the start of each scan
//   hold     : 1 = keep the current latched word (scanning continues)
//   o_seg    : active-low segments {dp,g..a}; dp always off
//   o_sel    : active-low one-hot digit select
// ---------------------------------------------------------------------------
module seg_hex_scan
    import board_dbg_pkg::*;
#(
    parameter int DIGITS  = 8,
    parameter int SEG_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   word,
    input  logic                  hold,
    output logic [7:0]            o_seg,
    output logic [DIGITS-1:0]     o_sel
);

    localparam int SW = clog2(SEG_DIV);
    localparam int DW = clog2(DIGITS);
    localparam logic [SW-1:0] SEG_LAST = SW'(SEG_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

    logic [SW-1:0]         seg_cnt;
    logic [DW-1:0]         dig_idx;
    logic [4*DIGITS-1:0]   word_q;
    logic                  advance;
    logic                  scan_wrap;
    logic [3:0]            nibble;

    assign advance   = (seg_cnt == SEG_LAST);
    // Index is about to return to 0: the next scan starts with a fresh word.
    assign scan_wrap = advance && (dig_idx == DIG_LAST);
    assign nibble    = 4'(word_q >> {dig_idx, 2'b00});

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_cnt <= '0;
            dig_idx <= '0;
            word_q  <= '0;
            o_sel   <= ~DIGITS'(1);
            o_seg   <= 8'hFF;
        end else begin
            seg_cnt <= advance ? '0 : seg_cnt + 1'b1;
            if (advance) begin
                dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
            end
            if (scan_wrap && !hold) begin
                word_q <= word;
            end
            // Select and segments come from the same index, so they always
            // change on the same clk.
            o_sel <= ~(DIGITS'(1) << dig_idx);
            o_seg <= HEX_SEG[nibble];
        end
    end

endmodule

// File: rtl/board_debug_ctrl.sv
// ---------------------------------------------------------------------------
// board_debug_ctrl
//   Run/step/halt/breakpoint controller for the board CPU plus a probe
//   display. All timing is done with enables on the single clock clk; the
//   CPU advances only on clks where cpu_en is 1.
// Ports:
//   clk   : board clock
//   rst   : synchronous active-high reset
//   bus   : board_dbg_if.slave
//     run        level, 1 = free-run request
//     step_btn   asynchronous button; each rising edge = one step request
//     choose     one-hot priority channel select (highest set bit wins,
//                all-zero selects channel 0)
//     probe      NUM_CH words, channel c at [c*DATA_W +: DATA_W]
//     pc, inst   current CPU pc / fetched instruction
//     bp_addr, bp_ena  breakpoint pc and enable
//     cpu_en     one-clk CPU advance enable
//     halted     1 in HALT or BREAK
//     step_count cpu_en pulses since reset (wraps)
//     o_seg/o_sel  multiplexed hex display, active-low
//     state      current controller state
// Optional macro: BOARD_DBG_FREEZE_EN - bus.freeze=1 holds the displayed
//   word (scanning continues, cpu_en unaffected).
// ---------------------------------------------------------------------------
module board_debug_ctrl
    import board_dbg_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 32,
    parameter int DIGITS  = 8,
    parameter int CPU_DIV = 20000,
    parameter int SEG_DIV = 4
) (
    input  logic      clk,
    input  logic      rst,
    board_dbg_if.slave bus
);

    localparam int CW = clog2(CPU_DIV);
    localparam int IW = clog2(NUM_CH);
    localparam logic [CW-1:0] CPU_LAST = CW'(CPU_DIV - 1);

    // -----------------------------------------------------------------------
    // Step button: two synchroniser flops, one history flop, registered
    // rising-edge pulse. During reset all three flops follow the button so
    // a level already present at reset release is not seen as an edge.
    // -----------------------------------------------------------------------
    logic btn_s1, btn_s2, btn_s3;
    logic step_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1   <= bus.step_btn;
            btn_s2   <= bus.step_btn;
            btn_s3   <= bus.step_btn;
            step_req <= 1'b0;
        end else begin
            btn_s1   <= bus.step_btn;
            btn_s2   <= btn_s1;
            btn_s3   <= btn_s2;
            step_req <= btn_s2 & ~btn_s3;
        end
    end

    // -----------------------------------------------------------------------
    // Controller FSM
    // -----------------------------------------------------------------------
    state_t          state, state_nxt;
    logic [CW-1:0]   cpu_cnt, cpu_cnt_nxt;
    logic            cpu_en_c;
    logic [31:0]     step_count_q;
    logic            inst_zero;
    logic            bp_hit;

    assign inst_zero = (bus.inst == '0);
    assign bp_hit    = bus.bp_ena && (bus.pc == bus.bp_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_HALT;
            cpu_cnt      <= '0;
            step_count_q <= '0;
        end else begin
            state   <= state_nxt;
            cpu_cnt <= cpu_cnt_nxt;
            if (cpu_en_c) step_count_q <= step_count_q + 32'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        cpu_cnt_nxt = '0;       // divider only holds a count while in RUN
        cpu_en_c    = 1'b0;
        case (state)
            ST_HALT: begin
                if (bus.run) begin
                    state_nxt = ST_RUN;
                end else if (step_req && !inst_zero) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                // End-of-program outranks halt request, which outranks the
                // breakpoint; each of them suppresses the pulse.
                if (inst_zero || !bus.run) begin
                    state_nxt = ST_HALT;
                end else if (cpu_cnt == CPU_LAST) begin
                    if (bp_hit) begin
                        state_nxt = ST_BREAK;
                    end else begin
                        cpu_en_c = 1'b1;
                    end
                end else begin
                    cpu_cnt_nxt = cpu_cnt + 1'b1;
                end
            end
            ST_STEP: begin
                cpu_en_c  = !inst_zero;
                state_nxt = ST_HALT;
            end
            ST_BREAK: begin
                if (step_req) begin
                    state_nxt = ST_STEP;
                end else if (!bus.run) begin
                    state_nxt = ST_HALT;
                end
            end
            default: state_nxt = ST_HALT;
        endcase
    end

    assign bus.cpu_en     = cpu_en_c;
    assign bus.halted     = (state == ST_HALT) || (state == ST_BREAK);
    assign bus.step_count = step_count_q;
    assign bus.state      = state;

    // -----------------------------------------------------------------------
    // Channel select: last set bit in ascending order is the highest one.
    // -----------------------------------------------------------------------
    logic [IW-1:0]     sel_idx;
    logic [DATA_W-1:0] sel_word;

    always_comb begin
        sel_idx = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.choose[c]) sel_idx = IW'(c);
        end
    end

    assign sel_word = DATA_W'(bus.probe >> (int'(sel_idx) * DATA_W));

    logic hold;
`ifdef BOARD_DBG_FREEZE_EN
    assign hold = bus.freeze;
`else
    assign hold = 1'b0;
`endif

    seg_hex_scan #(
        .DIGITS  (DIGITS),
        .SEG_DIV (SEG_DIV)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .word  (sel_word),
        .hold  (hold),
        .o_seg (bus.o_seg),
        .o_sel (bus.o_sel)
    );

endmodule

// File: tb/tb_board_debug_ctrl.sv
module tb_board_debug_ctrl;
  import board_dbg_pkg::*;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 32;
  localparam int DIGITS = 8;

  localparam logic [7:0] SEG_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  board_dbg_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();

  board_debug_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIGITS(DIGITS), .CPU_DIV(4), .SEG_DIV(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic hard_reset(input logic run_v, input logic btn_v);
    @(negedge clk);
    rst = 1'b1;
    bus.run = run_v;
    bus.step_btn = btn_v;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.run = 1'b1;
    bus.step_btn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.state !== ST_HALT) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, ST_HALT); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL reset_halted got=%b exp=1", bus.halted); end
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got=%b exp=0", bus.cpu_en); end
    checks++; if (bus.step_count !== 32'd0) begin errors++; $display("FAIL reset_step_count got=%0d exp=0", bus.step_count); end
    checks++; if (bus.o_seg !== 8'hFF) begin errors++; $display("FAIL reset_o_seg got=%h exp=ff", bus.o_seg); end
    checks++; if (bus.o_sel !== 8'hFE) begin errors++; $display("FAIL reset_o_sel got=%h exp=fe", bus.o_sel); end
    rst = 1'b0;
  endtask

  task automatic test_run();
    // Reset released with run=1 held: RUN from the first clk, pulse every 4th.
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (bus.state !== ST_RUN) begin errors++; $display("FAIL run_entry got=%0d exp=%0d", bus.state, ST_RUN); end
      end
      checks++;
      if (bus.cpu_en !== ((k % 4) == 0)) begin
        errors++; $display("FAIL run_cpu_en k=%0d got=%b exp=%b", k, bus.cpu_en, (k % 4) == 0);
      end
    end
    checks++; if (bus.step_count !== 32'd3) begin errors++; $display("FAIL run_step_count got=%0d exp=3", bus.step_count); end
  endtask

  task automatic test_lost_step();
    // step_btn rises together with rst: no step may follow reset.
    hard_reset(1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.cpu_en !== 1'b0 || bus.state !== ST_HALT) begin
        errors++; $display("FAIL lost_step k=%0d got_en=%b got_state=%0d exp_en=0 exp_state=0", k, bus.cpu_en, bus.state);
      end
    end
    bus.step_btn = 1'b0;
  endtask

  task automatic test_step();
    bus.inst = 32'h20080001;
    hard_reset(1'b0, 1'b0);
    @(negedge clk);
    bus.step_btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.cpu_en !== (k == 4)) begin
        errors++; $display("FAIL step_cpu_en k=%0d got=%b exp=%b", k, bus.cpu_en, k == 4);
      end
      if (k == 4) begin
        checks++; if (bus.state !== ST_STEP) begin errors++; $display("FAIL step_state got=%0d exp=%0d", bus.state, ST_STEP); end
      end
      if (k == 6) begin
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL step_halted got=%b exp=1", bus.halted); end
      end
      if (k == 2) bus.step_btn = 1'b0;
    end
    checks++; if (bus.step_count !== 32'd1) begin errors++; $display("FAIL step_count got=%0d exp=1", bus.step_count); end
  endtask

  task automatic test_breakpoint();
    int   pulses;
    logic seen;
    logic en;
    pulses = 0;
    seen = 1'b0;
    bus.inst = 32'h20080001;
    bus.pc = 32'h00400000;
    bus.bp_addr = 32'h00400010;
    bus.bp_ena = 1'b1;
    hard_reset(1'b0, 1'b0);
    @(negedge clk);
    bus.run = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      en = bus.cpu_en;
      if (bus.state === ST_BREAK) begin
        seen = 1'b1;
      end else begin
        if (en) pulses++;
        @(posedge clk);
        #1;
        if (en) bus.pc = bus.pc + 32'd4;
      end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_reached got=%b exp=1 (timeout)", seen); end
    checks++; if (pulses != 4) begin errors++; $display("FAIL bp_pulses got=%0d exp=4", pulses); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL bp_halted got=%b exp=1", bus.halted); end
    // run stays 1: BREAK must hold with no pulses.
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.cpu_en !== 1'b0 || bus.state !== ST_BREAK) begin
        errors++; $display("FAIL bp_hold k=%0d got_en=%b got_state=%0d exp_en=0 exp_state=3", k, bus.cpu_en, bus.state);
      end
    end
    bus.step_btn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (bus.cpu_en !== (k == 4)) begin
        errors++; $display("FAIL bp_step k=%0d got=%b exp=%b", k, bus.cpu_en, k == 4);
      end
      if (k == 2) bus.step_btn = 1'b0;
    end
    bus.run = 1'b0;
    bus.bp_ena = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.state !== ST_HALT) begin errors++; $display("FAIL bp_exit got=%0d exp=%0d", bus.state, ST_HALT); end
    checks++; if (bus.step_count !== 32'd5) begin errors++; $display("FAIL bp_step_count got=%0d exp=5", bus.step_count); end
  endtask

  task automatic test_end_of_program();
    bus.inst = 32'h00000001;
    bus.bp_ena = 1'b0;
    hard_reset(1'b0, 1'b0);
    @(negedge clk);
    bus.run = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.cpu_en !== (k == 4)) begin
        errors++; $display("FAIL eop_warm k=%0d got=%b exp=%b", k, bus.cpu_en, k == 4);
      end
    end
    bus.inst = 32'h0;
    #1;
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL eop_now got=%b exp=0", bus.cpu_en); end
    @(negedge clk);
    checks++; if (bus.state !== ST_HALT) begin errors++; $display("FAIL eop_halt got=%0d exp=%0d", bus.state, ST_HALT); end
    bus.run = 1'b0;
    bus.step_btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.cpu_en !== 1'b0 || bus.state !== ST_HALT) begin
        errors++; $display("FAIL eop_step k=%0d got_en=%b got_state=%0d exp_en=0 exp_state=0", k, bus.cpu_en, bus.state);
      end
      if (k == 2) bus.step_btn = 1'b0;
    end
    checks++; if (bus.step_count !== 32'd1) begin errors++; $display("FAIL eop_step_count got=%0d exp=1", bus.step_count); end
  endtask

  task automatic test_display();
    logic [31:0] word;
    logic [7:0]  seen;
    logic [7:0]  exp_seg;
    int          d;
    int          zeros;
    bus.probe = '0;
    bus.probe[0*DATA_W +: DATA_W] = 32'h0F1E2D3C;
    bus.probe[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    bus.probe[5*DATA_W +: DATA_W] = 32'h1234ABCD;
    for (int pass = 0; pass < 2; pass++) begin
      bus.choose = (pass == 0) ? 8'b0010_0100 : 8'b0000_0000;
      word = (pass == 0) ? 32'h1234ABCD : 32'h0F1E2D3C;
      repeat (20) @(negedge clk);
      seen = 8'h00;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        d = 0;
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
          if (bus.o_sel[i] === 1'b0) begin d = i; zeros++; end
        end
        seen[d] = 1'b1;
        exp_seg = SEG_TBL[word[d*4 +: 4]];
        checks++;
        if (zeros != 1) begin errors++; $display("FAIL disp_sel pass=%0d got=%h exp=one_cold", pass, bus.o_sel); end
        checks++;
        if (bus.o_seg !== exp_seg) begin
          errors++; $display("FAIL disp_seg pass=%0d digit=%0d got=%h exp=%h", pass, d, bus.o_seg, exp_seg);
        end
        if (pass == 0 && d == 0) begin
          checks++; if (bus.o_seg !== 8'hA1) begin errors++; $display("FAIL disp_digit0 got=%h exp=a1", bus.o_seg); end
        end
        if (pass == 0 && d == 7) begin
          checks++; if (bus.o_seg !== 8'hF9) begin errors++; $display("FAIL disp_digit7 got=%h exp=f9", bus.o_seg); end
        end
      end
      checks++; if (seen !== 8'hFF) begin errors++; $display("FAIL disp_cover pass=%0d got=%h exp=ff", pass, seen); end
    end
  endtask

`ifdef BOARD_DBG_FREEZE_EN
  task automatic test_freeze();
    logic [31:0] word;
    logic [7:0]  exp_seg;
    int          d;
    bus.choose = 8'b0010_0000;
    repeat (20) @(negedge clk);
    bus.freeze = 1'b1;
    bus.probe[5*DATA_W +: DATA_W] = 32'h55AA0FF0;
    word = 32'h1234ABCD;
    for (int k = 0; k < 24 + 10 + 8; k++) begin
      @(negedge clk);
      if (k == 24) begin
        bus.freeze = 1'b0;
        word = 32'h55AA0FF0;
      end
      if (k < 24 || k >= 34) begin
        d = 0;
        for (int i = 0; i < 8; i++) if (bus.o_sel[i] === 1'b0) d = i;
        exp_seg = SEG_TBL[word[d*4 +: 4]];
        checks++;
        if (bus.o_seg !== exp_seg) begin
          errors++; $display("FAIL freeze_seg k=%0d digit=%0d got=%h exp=%h", k, d, bus.o_seg, exp_seg);
        end
      end
    end
  endtask
`endif

  initial begin
    bus.run = 1'b0;
    bus.step_btn = 1'b0;
    bus.choose = '0;
    bus.probe = '0;
    bus.pc = '0;
    bus.inst = 32'h20080001;
    bus.bp_addr = '0;
    bus.bp_ena = 1'b0;
`ifdef BOARD_DBG_FREEZE_EN
    bus.freeze = 1'b0;
`endif
    test_reset();
    test_run();
    test_lost_step();
    test_step();
    test_breakpoint();
    test_end_of_program();
    test_display();
`ifdef BOARD_DBG_FREEZE_EN
    test_freeze();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
